sys_arr_result_collector: RTL
=============================

Name: sys_arr_result_collector

Overview:
- Receiving end of the systolic array's bottom-row outputs. Column j's 16-bit result for a given result row arrives j cycles after column 0's, qualified by its per-column active bit.
- The block deskews the columns, packs each aligned result row into one word, and buffers it in a small FIFO.
- Words are presented downstream on a valid/ready handshake with a row index and a last flag.
- The array cannot stall, so buffer overrun and skew faults are reported through sticky flags.

Parameters:
- WIDTH_HEIGHT, 2, array columns; must match the array's width_height.
- SUM_W, 16, bits per column result.
- FIFO_DEPTH, 4, aligned-row entries buffered; power of two, at least 2.
- ROWS, 2, result rows per tile; drives row_idx wrap and last.

Ports:
- clock  in  1  rising-edge clock shared with the array.
- reset  in  1  synchronous, active-high reset.
- maccout  in  SUM_W*WIDTH_HEIGHT  bottom-row results; column 0 in the LSBs.
- activeout  in  WIDTH_HEIGHT  per-column result-valid bits; bit j qualifies column j.
- out_valid  out  1  out_data, row_idx and out_last are valid.
- out_ready  in  1  downstream accepts the word this cycle.
- out_data  out  SUM_W*WIDTH_HEIGHT  aligned result row; column 0 in the LSBs.
- row_idx  out  clog2(ROWS) (minimum 1)  index of the presented row within the tile.
- out_last  out  1  high when row_idx == ROWS-1.
- overflow  out  1  sticky: an aligned row was dropped because the FIFO was full.
- skew_err  out  1  sticky: delayed column valid bits disagreed.
- fill  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, synchronous, takes priority over every other event. It clears:
  - delay lines and FIFO (fill=0, out_valid=0);
  - out_data=0, row_idx=0, out_last=0 (out_last=1 when ROWS==1);
  - overflow=0, skew_err=0.
- Reset mid-operation discards every in-flight and buffered row.
- Deskew:
  - Column j's {activeout[j], maccout slice j} passes through a register delay of WIDTH_HEIGHT-1-j cycles. Column WIDTH_HEIGHT-1 has no delay.
  - In cycle t all delayed columns belong to the same row.
  - Aligned-valid = AND of the delayed valid bits.
- Skew check: if the delayed valid bits are neither all 0 nor all 1, skew_err sets and that cycle's row is not pushed.
- Push:
  - An aligned-valid row is written at the edge ending cycle t.
  - Latency: raw arrival of the last column in cycle t, with the FIFO empty, gives out_valid=1 in cycle t+1. The first column's data arrives WIDTH_HEIGHT-1 cycles earlier.
- Pop: occurs when out_valid && out_ready. out_data, row_idx and out_last are taken from the FIFO head, with no combinational path from maccout.
- Full boundary:
  - A push while fill==FIFO_DEPTH with no pop in the same cycle drops the row and sets overflow.
  - A push and a pop in the same cycle while full are both accepted; fill is unchanged.
- Empty boundary: a push and a pop in the same cycle while empty cannot occur (out_valid=0). The pushed row appears the next cycle.
- fill increments on push-only, decrements on pop-only, and is unchanged otherwise.
- row_idx:
  - Tagged at push time from a push counter that increments per accepted row and wraps ROWS-1 → 0.
  - Dropped rows do not advance the counter.
  - The tag is stored alongside the data in the FIFO.
- Sticky flags clear only on reset.
- Holding rule: out_data/out_valid hold stable while out_valid && !out_ready.
- Widths: data passes through unmodified; no arithmetic on the results.

Decomposition:
- Shared package contents:
  - SUM_W;
  - a clog2 function;
  - a column-slice helper (offset = j*SUM_W).
- One natural sub-module, sys_arr_col_delay: a parameterised DEPTH-stage register pipe for {valid, data} with synchronous reset. It is instantiated per column with DEPTH = WIDTH_HEIGHT-1-j, and DEPTH=0 is a wire-through.
- The FIFO is inline: register array, read/write pointers, and a fill counter.

Test Plan:
1. Nominal deskew (WIDTH_HEIGHT=2, ROWS=2):
   - Stimulus: col0 = 0x0011 valid in cycle 5, col1 = 0x0022 valid in cycle 6; then col0 = 0x0033 in cycle 6, col1 = 0x0044 in cycle 7; out_ready=1.
   - Response: cycle 7 gives out_data=0x00220011, row_idx=0, last=0; cycle 8 gives 0x00440033, row_idx=1, last=1.
2. Backpressure and overflow (FIFO_DEPTH=4):
   - Stimulus: out_ready=0; stream 5 aligned rows with values 1..5.
   - Response: fill reaches 4 and overflow=1. Releasing ready yields rows 1..4 in order with row_idx 0,1,0,1; row 5 is absent.
3. Full with simultaneous push and pop: fill=4, out_ready=1, a new row arrives → accepted, fill stays 4, overflow stays 0.
4. Skew fault: activeout col0=1 in cycle 5 with no col1 in cycle 6 → skew_err=1 from cycle 7, no push, fill unchanged.
5. Reset mid-stream: reset=1 for one cycle with 3 rows buffered and overflow=1 → next cycle out_valid=0, fill=0, overflow=0, row_idx=0; the next row is tagged row_idx 0.
6. Hold stability: out_valid=1, out_ready=0 for 3 cycles → out_data unchanged; the pop occurs in the cycle ready rises.

Source files
------------

// File: rtl/sys_arr_result_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_arr_result_collector_pkg
// Description : Shared width constant and helpers for the result collector.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_arr_result_collector_pkg;

    localparam int SUM_W = 16;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Bit offset of column j inside a packed row of w-bit columns.
    function automatic int col_offset(input int j, input int w);
        return j * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_arr_col_delay.sv
`default_nettype none
// ============================================================================
// Module      : sys_arr_col_delay
// Description : DEPTH-stage {valid, data} register pipe; DEPTH=0 passes through.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_arr_col_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clock ^ reset;
            assign valid_o          = valid_i;
            assign data_o           = data_i;
        end else begin : g_pipe
            logic [DEPTH-1:0] vld_q;
            logic [W-1:0]     dat_q [DEPTH];

            always_ff @(posedge clock) begin
                if (reset) begin
                    vld_q <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= valid_i;
                    dat_q[0] <= data_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign valid_o = vld_q[DEPTH-1];
            assign data_o  = dat_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sys_arr_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : sys_arr_result_collector
// Description : Deskews systolic bottom-row results, packs rows, buffers them.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_arr_result_collector
    import sys_arr_result_collector_pkg::*;
#(
    parameter int WIDTH_HEIGHT = 2,
    parameter int SUM_W        = sys_arr_result_collector_pkg::SUM_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int ROWS         = 2
) (
    input  logic                                                  clock,
    input  logic                                                  reset,
    input  logic [SUM_W*WIDTH_HEIGHT-1:0]                         maccout,
    input  logic [WIDTH_HEIGHT-1:0]                               activeout,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [SUM_W*WIDTH_HEIGHT-1:0]                         out_data,
    output logic [((clog2(ROWS) < 1) ? 1 : clog2(ROWS))-1:0]      row_idx,
    output logic                                                  out_last,
    output logic                                                  overflow,
    output logic                                                  skew_err,
    output logic [clog2(FIFO_DEPTH):0]                            fill
);

    localparam int DW = SUM_W * WIDTH_HEIGHT;
    localparam int RW = (clog2(ROWS) < 1) ? 1 : clog2(ROWS);
    localparam int AW = clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;

    logic [WIDTH_HEIGHT-1:0] w_dly_valid;
    logic [DW-1:0]           w_dly_data;

    // Column j waits WIDTH_HEIGHT-1-j cycles so every column lines up with the last one.
    generate
        for (genvar j = 0; j < WIDTH_HEIGHT; j++) begin : g_col
            sys_arr_col_delay #(
                .DEPTH (WIDTH_HEIGHT - 1 - j),
                .W     (SUM_W)
            ) u_dly (
                .clock   (clock),
                .reset   (reset),
                .valid_i (activeout[j]),
                .data_i  (maccout[col_offset(j, SUM_W) +: SUM_W]),
                .valid_o (w_dly_valid[j]),
                .data_o  (w_dly_data[col_offset(j, SUM_W) +: SUM_W])
            );
        end
    endgenerate

    logic [DW-1:0]  mem_q [FIFO_DEPTH];
    logic [RW-1:0]  tag_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [FW-1:0]  fill_q;
    logic [FW-1:0]  fill_d;
    logic [RW-1:0]  row_cnt_q;
    logic [RW-1:0]  row_cnt_d;
    logic           overflow_q;
    logic           skew_err_q;

    logic w_all_valid;
    logic w_skew;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_all_valid = &w_dly_valid;
    assign w_skew      = (|w_dly_valid) & ~w_all_valid;
    assign w_full      = (fill_q == FW'(FIFO_DEPTH));
    assign w_pop       = (fill_q != '0) && out_ready;
    // A full FIFO still takes a row when the head leaves in the same cycle.
    assign w_push      = w_all_valid && (!w_full || w_pop);
    assign w_drop      = w_all_valid && w_full && !w_pop;

    always_comb begin
        fill_d    = fill_q;
        row_cnt_d = row_cnt_q;
        if (w_push && !w_pop) begin
            fill_d = fill_q + FW'(1);
        end else if (w_pop && !w_push) begin
            fill_d = fill_q - FW'(1);
        end
        if (w_push) begin
            row_cnt_d = (row_cnt_q == RW'(ROWS - 1)) ? '0 : row_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
            skew_err_q <= 1'b0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= w_dly_data;
                tag_q[wr_ptr_q] <= row_cnt_q;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            fill_q    <= fill_d;
            row_cnt_q <= row_cnt_d;
            if (w_drop) begin
                overflow_q <= 1'b1;
            end
            if (w_skew) begin
                skew_err_q <= 1'b1;
            end
        end
    end

    // Head entry is gated so an empty FIFO presents zeros rather than stale data.
    assign out_valid = (fill_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign row_idx   = out_valid ? tag_q[rd_ptr_q] : '0;
    assign out_last  = (row_idx == RW'(ROWS - 1));
    assign overflow  = overflow_q;
    assign skew_err  = skew_err_q;
    assign fill      = fill_q;

endmodule
`default_nettype wire
